rlc_game_system_cpu_oci_dct_ctrl: RTL and testbench
===================================================

// Module: rlc_game_system_cpu_oci_dct_ctrl
// PURPOSE
//  Sequencer for the CPU OCI direct-control-transfer (DCT) trace datapath. Packs 3-bit DCT
//  codes from the trace source into the 30-bit dct_buffer and tracks dct_count. Closes a
//  frame on full, flush, idle timeout or test_ending, and hands the frame to the trace sink
//  over a valid/ready handshake. The packer keeps filling while one closed frame waits.
// PARAMETERS
//  SLOTS      10  codes per frame; buffer width = SLOTS*CODE_W
//  CODE_W     3   bits per DCT code
//  TIMEOUT    64  idle cycles with a partial frame before forced close (>=2)
//  OVF_W      8   width of saturating overflow counter
// PORTS
//  clk           in   1   sole clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  dct_valid     in   1   dct_code valid this cycle; no ready, a code is accepted or dropped
//  dct_code      in   3   DCT code
//  flush         in   1   pulse: close partial frame
//  test_ending   in   1   level: treated as flush every cycle while high
//  dct_buffer    out  30  live accumulator; slot n at [3n+2:3n]
//  dct_count     out  4   live slots filled, 0..10
//  frame_valid   out  1   closed frame held on frame_data
//  frame_data    out  30  closed frame; unused slots read 0
//  frame_count   out  4   slots used in frame_data, 1..10
//  frame_ready   in   1   sink accepts frame when frame_valid&&frame_ready
//  overflow_cnt  out  8   codes dropped, saturates at all-ones
//  test_has_ended out 1   test_ending high, accumulator empty, frame_valid low
// BEHAVIOUR
//  - Reset (async assert, sync release): every output and internal register is 0, timer is 0.
//  - Accept: dct_valid && dct_count<SLOTS. The code is written to slot dct_count and
//    dct_count is incremented at the next edge.
//  - Drop: dct_valid && dct_count==SLOTS. overflow_cnt is incremented (saturating) and the
//    accumulator is unchanged.
//  - Close request, evaluated after this cycle's accept: any of
//    count'==SLOTS; (flush||test_ending) && count'>0; timer==TIMEOUT-1 && count'>0.
//  - Close is granted when the output register is free or frees this cycle (frame_valid&&frame_ready).
//    On grant: frame_data<=acc', frame_count<=count', frame_valid<=1, acc<=0, dct_count<=0.
//  - If the close request is not granted, the accumulator holds its contents and the request
//    re-evaluates every cycle.
//  - Latency: a code accepted in cycle t that fills slot 10 gives frame_valid=1 in cycle t+1
//    when the output register is free.
//  - Closing timing:
//    - flush and an accepted code in the same cycle: the code is included, then the frame closes.
//    - 10th code and frame_ready in the same cycle with an old frame pending: the old frame
//      leaves and the new frame loads. No bubble; sink throughput is 1 frame/cycle.
//  - frame_valid stays high and frame_data/frame_count stay stable until the handshake.
//    frame_valid then drops the next cycle unless a new close is granted.
//  - Idle timer: cleared on accept and on grant. Increments while dct_count>0 and no accept.
//    Holds at TIMEOUT-1 while close is blocked.
//  - Empty flush (count'==0): no effect and no frame.
//  - Reset mid-frame discards the accumulator and any pending frame. No partial output.
//  - States (derived): EMPTY (count=0), FILL (0<count<SLOTS), FULL (count=SLOTS, blocked),
//    combined with OUT_FREE / OUT_HELD.
//    - FULL is reachable only while OUT_HELD.
//    - FULL->EMPTY on grant.
// STRUCTURE
//  - Package rlc_game_system_cpu_oci_dct_pkg holds:
//    - DCT_SLOTS, DCT_CODE_W, DCT_BUF_W=30, DCT_CNT_W=4;
//    - DCT code enum: NOP, BR_T, BR_NT, CALL, RET, EXC, IRQ, RSV.
//  - One sub-module, rlc_game_system_cpu_oci_dct_idle_timer: clear/enable/hold inputs and a
//    single-cycle expire output.
//  - Packer, output register and overflow counter stay inline.
// TESTING
//  1. Reset, then 10 back-to-back codes 1..7,0,1,2 with frame_ready=1.
//     -> frame_valid for 1 cycle at t+1, frame_data=30'o2107654321, frame_count=10.
//  2. 3 codes (5,5,5), then idle. -> frame closes at TIMEOUT cycles after the 3rd accept,
//     frame_data=30'o555, frame_count=3.
//  3. frame_ready=0, then 21 codes. -> frame 1 held stable, accumulator full, 1 drop,
//     overflow_cnt=1. Raise frame_ready -> frame 2 loads with no bubble.
//  4. flush in the same cycle as the 4th code. -> frame_count=4 including that code.
//     flush while empty -> no frame.
//  5. reset_n low mid-frame with frame_valid=1. -> all outputs 0 immediately, no frame
//     after release.
//  6. test_ending high with 2 codes buffered and the sink stalled 5 cycles.
//     -> frame_count=2 delivered, then test_has_ended=1. 300 drops -> overflow_cnt=255.

Source files
------------

// File: rtl/rlc_game_system_cpu_oci_dct_pkg.sv
// Shared constants, DCT code set and fill-state encoding for the CPU OCI DCT trace sequencer.
package rlc_game_system_cpu_oci_dct_pkg;

    localparam int DCT_SLOTS   = 10;
    localparam int DCT_CODE_W  = 3;
    localparam int DCT_BUF_W   = DCT_SLOTS * DCT_CODE_W;
    localparam int DCT_CNT_W   = 4;
    localparam int DCT_TIMEOUT = 64;
    localparam int DCT_OVF_W   = 8;

    typedef enum logic [DCT_CODE_W-1:0] {
        NOP   = 3'd0,
        BR_T  = 3'd1,
        BR_NT = 3'd2,
        CALL  = 3'd3,
        RET   = 3'd4,
        EXC   = 3'd5,
        IRQ   = 3'd6,
        RSV   = 3'd7
    } dct_code_e;

    // Accumulator occupancy; FILL_FULL only persists while the output register is held.
    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

endpackage

// File: rtl/rlc_game_system_cpu_oci_dct_ctrl_if.sv
// Trace-source and trace-sink signals of the DCT sequencer; master is the environment, slave the sequencer.
interface rlc_game_system_cpu_oci_dct_ctrl_if
    import rlc_game_system_cpu_oci_dct_pkg::*;
#(
    parameter int CODE_W = DCT_CODE_W,
    parameter int BUF_W  = DCT_BUF_W,
    parameter int CNT_W  = DCT_CNT_W
);

    logic              dct_valid;
    logic [CODE_W-1:0] dct_code;
    logic              flush;
    logic              test_ending;
    logic              frame_valid;
    logic [BUF_W-1:0]  frame_data;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_ready;

    modport master (
        output dct_valid,
        output dct_code,
        output flush,
        output test_ending,
        output frame_ready,
        input  frame_valid,
        input  frame_data,
        input  frame_count
    );

    modport slave (
        input  dct_valid,
        input  dct_code,
        input  flush,
        input  test_ending,
        input  frame_ready,
        output frame_valid,
        output frame_data,
        output frame_count
    );

endinterface

// File: rtl/rlc_game_system_cpu_oci_dct_idle_timer.sv
// Idle timer for a partially filled frame; expire flags the last idle cycle before a forced close.
module rlc_game_system_cpu_oci_dct_idle_timer
    import rlc_game_system_cpu_oci_dct_pkg::*;
#(
    parameter int TIMEOUT = DCT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic hold,
    output logic expire
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] value;

    // Once expired with a blocked close, the value parks at LAST until the close is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable && !(hold && expire)) begin
            value <= value + TW'(1);
        end
    end

    assign expire = (value == LAST);

endmodule

// File: rtl/rlc_game_system_cpu_oci_dct_ctrl.sv
// DCT trace sequencer: packs 3-bit codes into a frame accumulator and hands closed frames
// to the trace sink through a one-deep output register.
module rlc_game_system_cpu_oci_dct_ctrl
    import rlc_game_system_cpu_oci_dct_pkg::*;
#(
    parameter int SLOTS   = DCT_SLOTS,
    parameter int CODE_W  = DCT_CODE_W,
    parameter int TIMEOUT = DCT_TIMEOUT,
    parameter int OVF_W   = DCT_OVF_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    rlc_game_system_cpu_oci_dct_ctrl_if.slave dct,
    output logic [SLOTS*CODE_W-1:0]      dct_buffer,
    output logic [$clog2(SLOTS+1)-1:0]   dct_count,
    output logic [OVF_W-1:0]             overflow_cnt,
    output logic                         test_has_ended
);

    localparam int BUF_W = SLOTS * CODE_W;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    fill_state_e      fill_state;
    logic             accept;
    logic             drop;
    logic [BUF_W-1:0] acc_next;
    logic [CNT_W-1:0] count_next;
    logic             close_req;
    logic             out_free;
    logic             grant;
    logic             expire;

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (dct_count == '0) begin
            fill_state = FILL_EMPTY;
        end else if (dct_count == FULL_CNT) begin
            fill_state = FILL_FULL;
        end
    end

    // The close decision looks at the accumulator after this cycle's code, so a code
    // arriving together with flush or the tenth slot is part of the closed frame.
    always_comb begin
        accept     = dct.dct_valid && (fill_state != FILL_FULL);
        drop       = dct.dct_valid && (fill_state == FILL_FULL);
        acc_next   = dct_buffer;
        count_next = dct_count;
        if (accept) begin
            acc_next[dct_count*CODE_W +: CODE_W] = dct.dct_code;
            count_next = dct_count + CNT_W'(1);
        end
        close_req = (count_next != '0) &&
                    ((count_next == FULL_CNT) || dct.flush || dct.test_ending || expire);
        out_free  = !dct.frame_valid || dct.frame_ready;
        grant     = close_req && out_free;
    end

    rlc_game_system_cpu_oci_dct_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept || grant),
        .enable  (dct_count != '0),
        .hold    (close_req && !grant),
        .expire  (expire)
    );

    // A grant in the same cycle as a handshake reloads the output register, so the sink
    // can take one frame per cycle without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer      <= '0;
            dct_count       <= '0;
            dct.frame_valid <= 1'b0;
            dct.frame_data  <= '0;
            dct.frame_count <= '0;
        end else if (grant) begin
            dct_buffer      <= '0;
            dct_count       <= '0;
            dct.frame_valid <= 1'b1;
            dct.frame_data  <= acc_next;
            dct.frame_count <= count_next;
        end else begin
            dct_buffer <= acc_next;
            dct_count  <= count_next;
            if (dct.frame_valid && dct.frame_ready) begin
                dct.frame_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != '1)) begin
            overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
    end

    assign test_has_ended = dct.test_ending && (dct_count == '0) && !dct.frame_valid;

endmodule

// File: tb/tb_rlc_game_system_cpu_oci_dct_ctrl.sv
// Self-checking bench for the DCT sequencer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the frame packing rules.
module tb_rlc_game_system_cpu_oci_dct_ctrl;
    import rlc_game_system_cpu_oci_dct_pkg::*;

    localparam int SLOTS   = 10;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  overflow_cnt;
    logic        test_has_ended;

    int checks = 0;
    int errors = 0;

    rlc_game_system_cpu_oci_dct_ctrl_if dct_if ();

    rlc_game_system_cpu_oci_dct_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct            (dct_if),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow_cnt   (overflow_cnt),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    // Reference model: codes waiting in a queue, one optional pending frame, idle cycle count.
    int          m_slots[$];
    logic        m_pend_valid = 1'b0;
    logic [29:0] m_pend_data = '0;
    int          m_pend_count = 0;
    int          m_idle = 0;
    int          m_ovf = 0;
    logic        m_accept;
    logic        m_close;
    int          m_n;

    function automatic logic [29:0] packSlots(input int q[$]);
        logic [29:0] v = '0;
        foreach (q[i]) v = v | (30'(q[i] & 7) << (3 * i));
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_slots.delete();
            m_pend_valid = 1'b0;
            m_pend_data  = '0;
            m_pend_count = 0;
            m_idle       = 0;
            m_ovf        = 0;
        end else begin
            m_accept = dct_if.dct_valid && (m_slots.size() < SLOTS);
            if (dct_if.dct_valid && !m_accept && m_ovf < 255) m_ovf = m_ovf + 1;
            if (m_accept) m_slots.push_back(int'(dct_if.dct_code));
            m_n = m_slots.size();
            m_close = (m_n == SLOTS) ||
                      ((dct_if.flush || dct_if.test_ending) && m_n > 0) ||
                      (m_idle == TIMEOUT - 1 && m_n > 0);
            if (m_close && (!m_pend_valid || dct_if.frame_ready)) begin
                m_pend_valid = 1'b1;
                m_pend_data  = packSlots(m_slots);
                m_pend_count = m_n;
                m_slots.delete();
                m_idle = 0;
            end else begin
                if (m_pend_valid && dct_if.frame_ready) m_pend_valid = 1'b0;
                if (m_accept) m_idle = 0;
                else if (m_n > 0 && m_idle < TIMEOUT - 1) m_idle = m_idle + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int code, input logic fl,
                                 input logic te, input logic ready);
        dct_if.dct_valid   = valid;
        dct_if.dct_code    = 3'(code);
        dct_if.flush       = fl;
        dct_if.test_ending = te;
        dct_if.frame_ready = ready;
    endtask

    task automatic compareModel();
        logic te_now;
        te_now = dct_if.test_ending;
        checkOutput("model_dct_buffer", 32'(dct_buffer), 32'(packSlots(m_slots)));
        checkOutput("model_dct_count", 32'(dct_count), m_slots.size());
        checkOutput("model_frame_valid", 32'(dct_if.frame_valid), 32'(m_pend_valid));
        checkOutput("model_overflow_cnt", 32'(overflow_cnt), m_ovf);
        checkOutput("model_test_has_ended", 32'(test_has_ended),
                    32'(te_now && m_slots.size() == 0 && !m_pend_valid));
        if (m_pend_valid) begin
            checkOutput("model_frame_data", 32'(dct_if.frame_data), 32'(m_pend_data));
            checkOutput("model_frame_count", 32'(dct_if.frame_count), m_pend_count);
        end
    endtask

    // One clock: compare on the falling edge, return 2 time units after the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        compareModel();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int codes1[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        int q1[$];
        int q2[$];
        int c;

        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) stepCycle();
        checkOutput("reset_frame_valid", 32'(dct_if.frame_valid), 0);
        checkOutput("reset_dct_count", 32'(dct_count), 0);
        checkOutput("reset_dct_buffer", 32'(dct_buffer), 0);
        checkOutput("reset_overflow", 32'(overflow_cnt), 0);
        reset_n = 1'b1;
        stepCycle();

        $display("[TB] test 1: ten back-to-back codes");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, codes1[i], 0, 0, 1);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t1_frame_valid", 32'(dct_if.frame_valid), 1);
        checkOutput("t1_frame_data", 32'(dct_if.frame_data), 32'(30'o2107654321));
        checkOutput("t1_frame_count", 32'(dct_if.frame_count), 10);
        checkOutput("t1_dct_count", 32'(dct_count), 0);
        stepCycle();
        checkOutput("t1_valid_drops", 32'(dct_if.frame_valid), 0);

        $display("[TB] test 2: idle timeout close");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5, 0, 0, 1);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 1);
        repeat (TIMEOUT - 1) stepCycle();
        checkOutput("t2_not_yet_closed", 32'(dct_if.frame_valid), 0);
        stepCycle();
        checkOutput("t2_frame_valid", 32'(dct_if.frame_valid), 1);
        checkOutput("t2_frame_data", 32'(dct_if.frame_data), 32'(30'o555));
        checkOutput("t2_frame_count", 32'(dct_if.frame_count), 3);
        stepCycle();

        $display("[TB] test 3: stalled sink, full accumulator, drop");
        for (int i = 0; i < 21; i++) begin
            c = int'($urandom_range(0, 7));
            if (i < 10) q1.push_back(c);
            else if (i < 20) q2.push_back(c);
            applyStimulus(1, c, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_frame1_held", 32'(dct_if.frame_data), 32'(packSlots(q1)));
        checkOutput("t3_frame1_valid", 32'(dct_if.frame_valid), 1);
        checkOutput("t3_acc_full", 32'(dct_count), 10);
        checkOutput("t3_acc_data", 32'(dct_buffer), 32'(packSlots(q2)));
        checkOutput("t3_overflow", 32'(overflow_cnt), 1);
        applyStimulus(0, 0, 0, 0, 1);
        stepCycle();
        checkOutput("t3_frame2_valid", 32'(dct_if.frame_valid), 1);
        checkOutput("t3_frame2_data", 32'(dct_if.frame_data), 32'(packSlots(q2)));
        checkOutput("t3_acc_empty", 32'(dct_count), 0);
        stepCycle();
        checkOutput("t3_drained", 32'(dct_if.frame_valid), 0);

        $display("[TB] test 4: flush with code, flush while empty");
        q1.delete();
        for (int i = 0; i < 4; i++) begin
            c = int'($urandom_range(0, 7));
            q1.push_back(c);
            applyStimulus(1, c, (i == 3), 0, 1);
            stepCycle();
        end
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("t4_frame_valid", 32'(dct_if.frame_valid), 1);
        checkOutput("t4_frame_count", 32'(dct_if.frame_count), 4);
        checkOutput("t4_frame_data", 32'(dct_if.frame_data), 32'(packSlots(q1)));
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t4_empty_flush", 32'(dct_if.frame_valid), 0);
        stepCycle();

        $display("[TB] test 5: reset with a pending frame");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 7, 0, 0, 0);
            stepCycle();
        end
        checkOutput("t5_pending_before", 32'(dct_if.frame_valid), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_frame_valid", 32'(dct_if.frame_valid), 0);
        checkOutput("t5_rst_frame_data", 32'(dct_if.frame_data), 0);
        checkOutput("t5_rst_dct_count", 32'(dct_count), 0);
        checkOutput("t5_rst_dct_buffer", 32'(dct_buffer), 0);
        checkOutput("t5_rst_overflow", 32'(overflow_cnt), 0);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (2) stepCycle();
        reset_n = 1'b1;
        repeat (3) stepCycle();
        checkOutput("t5_no_frame_after", 32'(dct_if.frame_valid), 0);

        $display("[TB] test 6: test_ending with stalled sink, saturating drops");
        applyStimulus(1, 3, 1, 0, 0);
        stepCycle();
        applyStimulus(1, 6, 0, 0, 0);
        stepCycle();
        applyStimulus(1, 2, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 1, 0);
        repeat (5) stepCycle();
        checkOutput("t6_old_frame_held", 32'(dct_if.frame_count), 1);
        checkOutput("t6_acc_blocked", 32'(dct_count), 2);
        checkOutput("t6_not_ended", 32'(test_has_ended), 0);
        applyStimulus(0, 0, 0, 1, 1);
        stepCycle();
        checkOutput("t6_frame_count", 32'(dct_if.frame_count), 2);
        checkOutput("t6_frame_data", 32'(dct_if.frame_data), 32'(30'o26));
        stepCycle();
        checkOutput("t6_ended", 32'(test_has_ended), 1);
        for (int i = 0; i < 320; i++) begin
            applyStimulus(1, i % 8, 0, 0, 0);
            stepCycle();
        end
        checkOutput("t6_overflow_sat", 32'(overflow_cnt), 255);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) stepCycle();

        $display("[TB] randomized traffic");
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                logic v;
                case (seg % 3)
                    0:       v = ($urandom_range(0, 3) != 0);
                    1:       v = ($urandom_range(0, 79) == 0);
                    default: v = ($urandom_range(0, 1) != 0);
                endcase
                applyStimulus(v, int'($urandom_range(0, 7)),
                              ($urandom_range(0, 15) == 0),
                              ($urandom_range(0, 63) == 0),
                              (seg % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 3) != 0));
                stepCycle();
            end
        end
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
